e203_nts_ctx_ctrl: RTL



---
 rtl/e203_nts_ctx_ctrl_pkg.sv | 23 ++
 rtl/e203_nts_ctx_ctrl_ram.sv | 27 ++
 rtl/e203_nts_ctx_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/e203_nts_ctx_ctrl_pkg.sv
// Shared parameters, state encoding and widths for the interrupt context stash.
package e203_nts_ctx_ctrl_pkg;

    localparam int XLEN           = 32;
    localparam int E203_NTS_GRP_W = 4 * XLEN;
    localparam int E203_NTS_DEPTH = 4;

    localparam int GRP_W   = E203_NTS_GRP_W;
    localparam int DEPTH   = E203_NTS_DEPTH;
    localparam int SLOT_W  = $clog2(DEPTH);
    localparam int AW      = SLOT_W + 2;          // slot x 4 beats
    localparam int WORDS   = DEPTH * 4;
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAVE   = 3'd1,
        ST_RD     = 3'd2,
        ST_RDLAST = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/e203_nts_ctx_ctrl_ram.sv
// Single-port context RAM: one 128-bit beat per word, 1-cycle read latency,
// a write in the same cycle suppresses the read.
module e203_nts_ctx_ctrl_ram
    import e203_nts_ctx_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [GRP_W-1:0] wdata,
    output logic [GRP_W-1:0] rdata
);

    logic [GRP_W-1:0] mem_q [WORDS];
    logic [GRP_W-1:0] rdata_q;

    // Storage array and registered read port; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/e203_nts_ctx_ctrl.sv
// Interrupt context stash: pushes a 4-group register snapshot onto a nested
// stack in RAM on save, pops and presents it back to the regfile on restore.
//
// Request semantics: save (save_2ram & irq_i) and restore_req are single-cycle
// strobes sampled on the rising edge; there is no back-pressure. A strobe seen
// while busy is remembered in a pend bit (one deep per type); a second one of
// the same type is merged and flagged in err_drop. restore_vld is a one-cycle
// pulse while reg_data*_o already hold the complete restored context.
module e203_nts_ctx_ctrl
    import e203_nts_ctx_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               save_2ram,
    input  logic               irq_i,
    input  logic [GRP_W-1:0]   reg_data1_i,
    input  logic [GRP_W-1:0]   reg_data2_i,
    input  logic [GRP_W-1:0]   reg_data3_i,
    input  logic [GRP_W-1:0]   reg_data4_i,
    input  logic               restore_req,
    input  logic               err_clr,
    output logic [GRP_W-1:0]   reg_data1_o,
    output logic [GRP_W-1:0]   reg_data2_o,
    output logic [GRP_W-1:0]   reg_data3_o,
    output logic [GRP_W-1:0]   reg_data4_o,
    output logic               restore_vld,
    output logic               busy,
    output logic [DEPTH_W-1:0] depth,
    output logic               err_ovf,
    output logic               err_unf,
    output logic               err_drop,
    output logic [2:0]         dbg_state
);

    state_t                  state_q, state_d;
    logic [1:0]              b_q, b_d;
    logic [DEPTH_W-1:0]      depth_q, depth_d;
    logic                    pend_save_q, pend_save_d;
    logic                    pend_rest_q, pend_rest_d;
    logic                    err_ovf_q, err_ovf_d;
    logic                    err_unf_q, err_unf_d;
    logic                    err_drop_q, err_drop_d;
    logic [3:0][GRP_W-1:0]   snap_q, snap_d;
    logic [3:0][GRP_W-1:0]   grp_q, grp_d;

    logic                    live_save;
    logic                    save_eff;
    logic                    rest_eff;
    logic                    set_ovf, set_unf, set_drop;
    logic [DEPTH_W-1:0]      rd_slot;
    logic [AW-1:0]           wr_addr, rd_addr;
    logic                    ram_we;
    logic [AW-1:0]           ram_addr;
    logic [GRP_W-1:0]        ram_wdata;
    logic [GRP_W-1:0]        ram_rdata;

    assign live_save = save_2ram & irq_i;
    assign save_eff  = live_save | pend_save_q;
    assign rest_eff  = restore_req | pend_rest_q;
    assign rd_slot   = depth_q - DEPTH_W'(1);
    assign wr_addr   = {depth_q[SLOT_W-1:0], b_q};
    assign rd_addr   = {rd_slot[SLOT_W-1:0], b_q};

    // Next-state, request arbitration, pend bookkeeping and RAM control.
    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        depth_d     = depth_q;
        pend_save_d = pend_save_q;
        pend_rest_d = pend_rest_q;
        snap_d      = snap_q;
        grp_d       = grp_q;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        set_drop    = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = rd_addr;
        ram_wdata   = snap_q[b_q];

        case (state_q)
            ST_IDLE: begin
                if (save_eff) begin
                    // Save has priority; a coincident restore waits in pend_rest.
                    if (live_save && pend_save_q) set_drop = 1'b1;
                    pend_save_d = 1'b0;
                    if (depth_q == DEPTH_W'(DEPTH)) begin
                        set_ovf = 1'b1;
                    end else begin
                        snap_d  = {reg_data4_i, reg_data3_i, reg_data2_i, reg_data1_i};
                        state_d = ST_SAVE;
                        b_d     = 2'd0;
                    end
                    if (restore_req) begin
                        if (pend_rest_q) set_drop = 1'b1;
                        pend_rest_d = 1'b1;
                    end
                end else if (rest_eff) begin
                    if (restore_req && pend_rest_q) set_drop = 1'b1;
                    pend_rest_d = 1'b0;
                    if (depth_q == '0) begin
                        set_unf = 1'b1;
                    end else begin
                        state_d = ST_RD;
                        b_d     = 2'd0;
                    end
                end
            end
            ST_SAVE: begin
                ram_we   = 1'b1;
                ram_addr = wr_addr;
                b_d      = b_q + 2'd1;
                if (b_q == 2'd3) begin
                    depth_d = depth_q + DEPTH_W'(1);
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                // Beat b-1 issued last cycle is on the RAM output now.
                b_d = b_q + 2'd1;
                if (b_q != 2'd0) grp_d[b_q - 2'd1] = ram_rdata;
                if (b_q == 2'd3) state_d = ST_RDLAST;
            end
            ST_RDLAST: begin
                grp_d[3] = ram_rdata;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                depth_d = depth_q - DEPTH_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Requests arriving mid-operation are queued one deep per type.
        if (state_q != ST_IDLE) begin
            if (live_save) begin
                if (pend_save_q) set_drop = 1'b1;
                pend_save_d = 1'b1;
            end
            if (restore_req) begin
                if (pend_rest_q) set_drop = 1'b1;
                pend_rest_d = 1'b1;
            end
        end
    end

    // Sticky error flags: a new event outranks a coincident clear.
    always_comb begin
        err_ovf_d  = (err_ovf_q  & ~err_clr) | set_ovf;
        err_unf_d  = (err_unf_q  & ~err_clr) | set_unf;
        err_drop_d = (err_drop_q & ~err_clr) | set_drop;
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            b_q         <= 2'd0;
            depth_q     <= '0;
            pend_save_q <= 1'b0;
            pend_rest_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            err_drop_q  <= 1'b0;
            snap_q      <= '0;
            grp_q       <= '0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            depth_q     <= depth_d;
            pend_save_q <= pend_save_d;
            pend_rest_q <= pend_rest_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
            err_drop_q  <= err_drop_d;
            snap_q      <= snap_d;
            grp_q       <= grp_d;
        end
    end

    e203_nts_ctx_ctrl_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign reg_data1_o = grp_q[0];
    assign reg_data2_o = grp_q[1];
    assign reg_data3_o = grp_q[2];
    assign reg_data4_o = grp_q[3];
    assign restore_vld = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign depth       = depth_q;
    assign err_ovf     = err_ovf_q;
    assign err_unf     = err_unf_q;
    assign err_drop    = err_drop_q;
    assign dbg_state   = state_q;

endmodule
